// File: rtl/match_subpixel.sv
// Sub-pixel disparity refinement: (x0 - pos) + y0/(y0 - y1) in fixed point via a
// fully pipelined restoring divider, buffered into a first-word-fall-through AXI-Stream FIFO.
module match_subpixel #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int OUT_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            vld_i,
  input  logic                            not_found_i,
  input  logic [DATA_WIDTH-1:0]           x0_i,
  input  logic [DATA_WIDTH-1:0]           y_sub_y0_i,
  input  logic [DATA_WIDTH-1:0]           y_sub_y1_i,
  input  logic [DATA_WIDTH-1:0]           pos_i,
  input  logic                            tlast_i,
  output logic [DATA_WIDTH+FRAC_BITS:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            overflow
);
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int RW  = DATA_WIDTH + 2;
  localparam int OW  = DATA_WIDTH + FRAC_BITS;
  localparam int AW  = $clog2(OUT_DEPTH);

  // stage 0 operands, all exact in DATA_WIDTH+1 bits
  logic signed [DW1-1:0] n_s, y1_s, d_s, x0_s, pos_s, int_s;
  logic                  zero_s, ones_s;

  assign n_s    = {y_sub_y0_i[DATA_WIDTH-1], y_sub_y0_i};
  assign y1_s   = {y_sub_y1_i[DATA_WIDTH-1], y_sub_y1_i};
  assign x0_s   = {x0_i[DATA_WIDTH-1], x0_i};
  assign pos_s  = {pos_i[DATA_WIDTH-1], pos_i};
  assign d_s    = n_s - y1_s;
  assign int_s  = x0_s - pos_s;
  assign zero_s = d_s[DW1-1] || (d_s == '0) || n_s[DW1-1];
  assign ones_s = !zero_s && (n_s >= d_s);

  // index k holds the state after k divider iterations
  logic                  v_reg    [0:FRAC_BITS];
  logic                  nf_reg   [0:FRAC_BITS];
  logic                  tl_reg   [0:FRAC_BITS];
  logic                  zero_reg [0:FRAC_BITS];
  logic                  ones_reg [0:FRAC_BITS];
  logic signed [DW1-1:0] int_reg  [0:FRAC_BITS];
  logic [FRAC_BITS-1:0]  q_reg    [0:FRAC_BITS];
  logic signed [RW-1:0]  r_reg    [0:FRAC_BITS-1];
  logic signed [DW1-1:0] d_reg    [0:FRAC_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg[0]    <= 1'b0;
      nf_reg[0]   <= 1'b0;
      tl_reg[0]   <= 1'b0;
      zero_reg[0] <= 1'b0;
      ones_reg[0] <= 1'b0;
      int_reg[0]  <= '0;
      q_reg[0]    <= '0;
      r_reg[0]    <= '0;
      d_reg[0]    <= '0;
    end else begin
      v_reg[0]    <= vld_i;
      nf_reg[0]   <= not_found_i;
      tl_reg[0]   <= tlast_i;
      zero_reg[0] <= zero_s;
      ones_reg[0] <= ones_s;
      int_reg[0]  <= int_s;
      q_reg[0]    <= '0;
      r_reg[0]    <= {n_s[DW1-1], n_s};
      d_reg[0]    <= d_s;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= FRAC_BITS; gi++) begin : g_stage
      logic signed [RW-1:0] r2, dx;
      logic                 ge;
      assign r2 = r_reg[gi-1] <<< 1;
      assign dx = {d_reg[gi-1][DW1-1], d_reg[gi-1]};
      assign ge = (r2 >= dx);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg[gi]    <= 1'b0;
          nf_reg[gi]   <= 1'b0;
          tl_reg[gi]   <= 1'b0;
          zero_reg[gi] <= 1'b0;
          ones_reg[gi] <= 1'b0;
          int_reg[gi]  <= '0;
          q_reg[gi]    <= '0;
        end else begin
          v_reg[gi]    <= v_reg[gi-1];
          nf_reg[gi]   <= nf_reg[gi-1];
          tl_reg[gi]   <= tl_reg[gi-1];
          zero_reg[gi] <= zero_reg[gi-1];
          ones_reg[gi] <= ones_reg[gi-1];
          int_reg[gi]  <= int_reg[gi-1];
          q_reg[gi]    <= (q_reg[gi-1] << 1) | FRAC_BITS'(ge);
        end
      end

      // the last iteration only needs its quotient bit, so no remainder is kept
      if (gi < FRAC_BITS) begin : g_rem
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_reg[gi] <= '0;
            d_reg[gi] <= '0;
          end else begin
            r_reg[gi] <= ge ? (r2 - dx) : r2;
            d_reg[gi] <= d_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic [FRAC_BITS-1:0]   frac;
  logic [DW1+FRAC_BITS-1:0] sum;
  logic [OW:0]            res_data;

  always_comb begin
    frac = q_reg[FRAC_BITS];
    if (zero_reg[FRAC_BITS])
      frac = '0;
    else if (ones_reg[FRAC_BITS])
      frac = '1;
    sum      = {int_reg[FRAC_BITS], {FRAC_BITS{1'b0}}} + {{DW1{1'b0}}, frac};
    res_data = nf_reg[FRAC_BITS] ? {1'b1, {OW{1'b0}}} : {1'b0, sum[OW-1:0]};
  end

  // output FIFO, pointers carry one wrap bit to tell full from empty
  logic [OW+1:0] mem [0:OUT_DEPTH-1];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop, wr_en;
  logic [OW+1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = v_reg[FRAC_BITS];
  assign pop   = !empty && m_axis_tready;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : head[OW:0];
  assign m_axis_tlast  = !empty && head[OW+1];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= {tl_reg[FRAC_BITS], res_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_match_subpixel.sv
// Randomized and directed bench for match_subpixel against a transaction-level
// model: arithmetic disparity, fixed pipeline delay and a bounded FIFO queue.
module tb_match_subpixel;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld_i = 1'b0, not_found_i = 1'b0, tlast_i = 1'b0;
  logic [DW-1:0] x0_i = '0, y_sub_y0_i = '0, y_sub_y1_i = '0, pos_i = '0;
  logic [DW+FB:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, overflow;
  logic          m_axis_tready = 1'b1;

  match_subpixel #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .not_found_i(not_found_i),
    .x0_i(x0_i), .y_sub_y0_i(y_sub_y0_i), .y_sub_y1_i(y_sub_y1_i), .pos_i(pos_i),
    .tlast_i(tlast_i), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW+FB:0] data; logic last; } pend_t;
  typedef struct { logic [DW+FB:0] data; logic last; } out_t;

  pend_t pend_q[$];
  out_t  mq[$];
  int    errors = 0, checks = 0, cyc = 0, rdy_mode = 0, drained = 0;
  logic  ovf_exp = 1'b0;

  function automatic logic [DW+FB:0] ref_result(int x0, int pos, int y0, int y1, bit nf);
    int d, frac, disp;
    logic [DW+FB-1:0] t;
    if (nf) return {1'b1, {(DW+FB){1'b0}}};
    d = y0 - y1;
    if (d <= 0 || y0 < 0) frac = 0;
    else if (y0 >= d)     frac = (1 << FB) - 1;
    else                  frac = (y0 * (1 << FB)) / d;
    disp = (x0 - pos) * (1 << FB) + frac;
    t = disp[DW+FB-1:0];
    return {1'b0, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: check outputs, drive inputs, advance the model to the next edge
  task automatic cycle(input bit v, input bit nf, input logic signed [DW-1:0] x0,
                       input logic signed [DW-1:0] pos, input logic signed [DW-1:0] y0,
                       input logic signed [DW-1:0] y1, input bit tl);
    bit pop;
    @(negedge clk);
    cyc++;
    chk("tvalid", m_axis_tvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("tdata", m_axis_tdata, mq[0].data);
      chk("tlast", m_axis_tlast, mq[0].last);
    end
    chk("overflow", overflow, ovf_exp);
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    vld_i = v; not_found_i = nf; tlast_i = tl;
    x0_i = x0; pos_i = pos; y_sub_y0_i = y0; y_sub_y1_i = y1;
    pop = (mq.size() != 0) && m_axis_tready;
    if (m_axis_tvalid && m_axis_tready) drained++;
    if (v) pend_q.push_back('{cyc + FB + 1, ref_result(x0, pos, y0, y1, nf), tl});
    if (pop) void'(mq.pop_front());
    if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      if (mq.size() < DEPTH) mq.push_back('{pend_q[0].data, pend_q[0].last});
      else ovf_exp = 1'b1;
      void'(pend_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_beat(input bit tl);
    logic signed [DW-1:0] x0, pos, y0, y1;
    x0  = DW'($urandom_range(0, 2000));
    pos = DW'($urandom_range(0, 2000));
    y0  = ($urandom_range(0, 3) == 0) ? DW'($urandom()) : DW'($urandom_range(0, 500));
    y1  = -DW'($urandom_range(0, 600));
    cycle(1, ($urandom_range(0, 15) == 0), x0, pos, y0, y1, tl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vld_i = 1'b0;
    pend_q.delete(); mq.delete(); ovf_exp = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // single beat on an idle pipe: latency, value and one-cycle valid pulse
  task automatic directed(input string tag, input int x0, input int pos, input int y0,
                          input int y1, input bit nf, input bit tl,
                          input logic [DW+FB:0] exp_data, input bit exp_last);
    bit found = 0;
    rdy_mode = 0;
    cycle(1, nf, DW'(x0), DW'(pos), DW'(y0), DW'(y1), tl);
    for (int k = 1; k <= 20 && !found; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      if (m_axis_tvalid) begin
        found = 1;
        chk({tag, "_latency"}, k, FB + 2);
        chk({tag, "_data"}, m_axis_tdata, exp_data);
        chk({tag, "_last"}, m_axis_tlast, exp_last);
      end
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk({tag, "_pulse"}, m_axis_tvalid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_tvalid", m_axis_tvalid, 0);
    chk("init_tdata", m_axis_tdata, 0);
    chk("init_overflow", overflow, 0);
    rst_n = 1'b1;

    directed("d128", 100, 90, 32, -96, 0, 0, 25'h0000A40, 0);
    directed("neg", 50, 60, 64, -64, 0, 0, 25'h0FFF680, 0);
    directed("third", 5, 5, 1, -2, 0, 0, 25'h0000055, 0);
    directed("n_neg", 3, 1, -5, -20, 0, 0, 25'h0000200, 0);
    directed("n_ge_d", 0, 0, 200, 50, 0, 0, 25'h00000FF, 0);
    directed("d_zero", 10, 20, 7, 7, 0, 0, 25'h0FFF600, 0);
    directed("nf", 9, 4, 30, -30, 1, 1, 25'h1000000, 1);

    // full row with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 1280; i++) rand_beat(i == 1279);
    rdy_mode = 0;
    idle(40);

    // saturate the FIFO with tready low
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < DEPTH + 3; i++) rand_beat(i == DEPTH + 2);
    idle(12);
    chk("sat_overflow", overflow, 1);
    chk("sat_tvalid", m_axis_tvalid, 1);
    rdy_mode = 0;
    drained = 0;
    idle(25);
    chk("sat_drain_count", drained, DEPTH);
    chk("sat_overflow_held", overflow, 1);

    // reset with 8 buffered and 5 in flight
    rdy_mode = 2;
    for (int i = 0; i < 13; i++) rand_beat(0);
    idle(4);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    do_reset();
    rdy_mode = 0;
    drained = 0;
    idle(15);
    chk("post_rst_stale", drained, 0);
    directed("post_rst", 100, 90, 32, -96, 0, 0, 25'h0000A40, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/match_subpixel.md
# match_subpixel

Sub-pixel refinement stage directly downstream of the phase-match core. Consumes each match result (x0, y_sub_y0, y_sub_y1, pixel position, not_found, tlast) and computes the fixed-point disparity `(x0 - pos) + y_sub_y0/(y_sub_y0 - y_sub_y1)` with a fully pipelined restoring divider. It emits the result on an AXI-Stream master through an output FIFO. The match core has no ready input, so this block never stalls its input; it absorbs downstream backpressure in the FIFO and flags loss.

## Interface
- DATA_WIDTH, 16, width of all signed input fields
- FRAC_BITS, 8, fractional bits of disparity (= divider stages)
- OUT_DEPTH, 16, output FIFO depth (power of 2, ≥2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vld_i  in  1  input beat valid, accepted unconditionally
- not_found_i  in  1  no match for this pixel
- x0_i  in  DATA_WIDTH  signed integer match column
- y_sub_y0_i  in  DATA_WIDTH  signed phase error at x0
- y_sub_y1_i  in  DATA_WIDTH  signed phase error at x0+1
- pos_i  in  DATA_WIDTH  signed source pixel position
- tlast_i  in  1  last pixel of row
- m_axis_tdata  out  DATA_WIDTH+FRAC_BITS+1  {not_found, disparity[DATA_WIDTH+FRAC_BITS-1:0] signed}
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  copy of tlast_i
- overflow  out  1  sticky: a result was dropped on full FIFO

## Operation
- Stage 0 (register on vld_i): n = y_sub_y0 sign-extended to DATA_WIDTH+1; d = y_sub_y0 - y_sub_y1 (DATA_WIDTH+1 bits, exact); int = x0 - pos (DATA_WIDTH+1 bits).
- Clamp classification at stage 0: d ≤ 0 or n < 0 → frac forced 0; n ≥ d (d > 0) → frac forced all ones (2^FRAC_BITS-1); otherwise divide.
- Divider: remainder r0 = n; stages k = 1..FRAC_BITS: r2 = r<<1; if r2 ≥ d then q bit = 1, r = r2 - d, else q bit = 0, r = r2. MSB first. Result = floor(n·2^FRAC_BITS / d). Remainder width DATA_WIDTH+2 to avoid overflow of r2.
- Final stage: disparity = (int <<< FRAC_BITS) + frac, truncated to DATA_WIDTH+FRAC_BITS bits two's complement. If not_found: disparity = 0, not_found bit = 1.
- Valid, not_found, tlast, int and clamp flags travel in lockstep with the divider pipeline; bubbles (vld_i=0) propagate as invalid stages. Pipeline has no enable and always advances.
- Output FIFO: push when final stage valid; pop on m_axis_tvalid & m_axis_tready; m_axis_tvalid = FIFO non-empty; head visible combinationally (first-word fall-through).
- Full: push while full and no pop → result dropped, overflow set and held until reset. Push while full with simultaneous pop → accepted, occupancy unchanged.
- Empty with simultaneous push: no bypass; data appears next cycle.
- Order preserved; tlast follows its own beat.

## Timing
- Reset (async assert, sync release): all pipeline valids 0, FIFO empty, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, overflow 0. Reset mid-stream discards all in-flight and buffered beats.
- Latency: vld_i high in cycle t → FIFO write in cycle t+FRAC_BITS+1 → m_axis_tvalid high in cycle t+FRAC_BITS+2 (FIFO empty). 10 cycles at defaults.
- Throughput: one input per cycle sustained; one output per cycle while tready high.
- m_axis_tdata/tlast stable while tvalid & ~tready.

## Test plan
- x0=100, pos=90, y_sub_y0=32, y_sub_y1=-96 (d=128), tready=1 → tdata disparity 2624 (0xA40), not_found 0, tvalid at t+10 for exactly one cycle.
- x0=50, pos=60, y_sub_y0=64, y_sub_y1=-64 → disparity -2432 (0x...F680); x0=5, pos=5, y_sub_y0=1, y_sub_y1=-2 → 85.
- Clamps: y_sub_y0=-5, y_sub_y1=-20 → frac 0; y_sub_y0=200, y_sub_y1=50 → frac 255; y_sub_y0=y_sub_y1=7 → frac 0; not_found_i=1, tlast_i=1 → tdata = {1, 0}, tlast 1.
- Back-to-back 1280-beat row, tlast on last, tready random 50% → all 1280 outputs in order vs. reference model, single tlast on final beat, overflow stays 0 only if FIFO never saturates (check model).
- tready=0, OUT_DEPTH+3 consecutive beats → FIFO holds first 16, 3 dropped, overflow=1; tready=1 → 16 beats drain in order, overflow remains 1.
- Assert rst_n low mid-row with 5 beats in pipeline and 8 in FIFO → tvalid 0 immediately, overflow 0; after release, new beat emerges at t+10 with no stale data.
